// File: rtl/tmds_serializer_if.sv
// Word handshake between the TMDS encoders and the serializer.
// One word set per transfer; channel ch occupies word_data[ch*10 +: 10].
interface tmds_serializer_if #(
    parameter int unsigned NUM_CH = 3
);
    logic                   word_valid;
    logic                   word_ready;
    logic [NUM_CH*10-1:0]   word_data;

    modport master (
        output word_valid,
        output word_data,
        input  word_ready
    );

    modport slave (
        input  word_valid,
        input  word_data,
        output word_ready
    );
endinterface

// File: rtl/tmds_serializer.sv
// N-channel TMDS word serializer running on the 5x pixel clock.
// Emits BITS_PER_CLK bits per cycle, LSB first, plus the matching TMDS clock-channel pattern.
module tmds_serializer #(
    parameter int unsigned NUM_CH       = 3,
    parameter int unsigned BITS_PER_CLK = 2,
    parameter logic [9:0]  IDLE_WORD    = 10'b1101010100,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                           clk_5x_pixel,
    input  logic                           reset_n,
    tmds_serializer_if.slave               word_if,
    output logic [NUM_CH*BITS_PER_CLK-1:0] ser_data,
    output logic [BITS_PER_CLK-1:0]        ser_clk,
    output logic                           load_strobe,
    output logic                           underrun,
    output logic [CNT_W-1:0]               underrun_count,
    input  logic                           underrun_clr
);
    localparam int unsigned     PHASES      = 10 / BITS_PER_CLK;
    localparam int unsigned     PH_W        = (PHASES > 1) ? $clog2(PHASES) : 1;
    localparam logic [PH_W-1:0] LAST_PHASE  = PH_W'(PHASES - 1);
    localparam logic [9:0]      CLK_PATTERN = 10'b0000011111;
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

    if (BITS_PER_CLK != 1 && BITS_PER_CLK != 2 && BITS_PER_CLK != 5 && BITS_PER_CLK != 10)
    begin : g_bad_bpc
        $error("tmds_serializer: BITS_PER_CLK must be 1, 2, 5 or 10");
    end

    if (NUM_CH == 0 || CNT_W == 0) begin : g_bad_size
        $error("tmds_serializer: NUM_CH and CNT_W must be non-zero");
    end

    logic [PH_W-1:0]        r_phase;
    logic                   r_hold_valid;
    logic [NUM_CH*10-1:0]   r_hold_data;
    logic [9:0]             r_shift [NUM_CH];
    logic [9:0]             r_clk_shift;
    logic                   r_underrun;
    logic [CNT_W-1:0]       r_underrun_count;

    logic                   w_load_cycle;
    logic                   w_ready;
    logic                   w_accept;
    logic                   w_underrun_evt;

    assign w_load_cycle   = (r_phase == LAST_PHASE);
    // Ready on the load cycle too: the held word leaves as the new one arrives.
    assign w_ready        = ~r_hold_valid | w_load_cycle;
    assign w_accept       = word_if.word_valid & w_ready;
    assign w_underrun_evt = w_load_cycle & ~r_hold_valid;

    assign word_if.word_ready = w_ready;

    always_ff @(posedge clk_5x_pixel or negedge reset_n) begin
        if (!reset_n) begin
            r_phase <= '0;
        end else if (w_load_cycle) begin
            r_phase <= '0;
        end else begin
            r_phase <= r_phase + 1'b1;
        end
    end

    always_ff @(posedge clk_5x_pixel or negedge reset_n) begin
        if (!reset_n) begin
            r_hold_valid <= 1'b0;
            r_hold_data  <= '0;
        end else if (w_accept) begin
            r_hold_valid <= 1'b1;
            r_hold_data  <= word_if.word_data;
        end else if (w_load_cycle) begin
            r_hold_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk_5x_pixel or negedge reset_n) begin
        if (!reset_n) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                r_shift[ch] <= IDLE_WORD;
            end
            r_clk_shift <= CLK_PATTERN;
        end else if (w_load_cycle) begin
            // The held word is the one loaded; a same-cycle accept waits for the next frame.
            for (int ch = 0; ch < NUM_CH; ch++) begin
                r_shift[ch] <= r_hold_valid ? r_hold_data[ch*10 +: 10] : IDLE_WORD;
            end
            r_clk_shift <= CLK_PATTERN;
        end else begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                r_shift[ch] <= r_shift[ch] >> BITS_PER_CLK;
            end
            r_clk_shift <= r_clk_shift >> BITS_PER_CLK;
        end
    end

    always_ff @(posedge clk_5x_pixel or negedge reset_n) begin
        if (!reset_n) begin
            r_underrun       <= 1'b0;
            r_underrun_count <= '0;
        end else if (underrun_clr) begin
            r_underrun       <= 1'b0;
            r_underrun_count <= '0;
        end else if (w_underrun_evt) begin
            r_underrun <= 1'b1;
            if (r_underrun_count != CNT_MAX) begin
                r_underrun_count <= r_underrun_count + 1'b1;
            end
        end
    end

    always_comb begin
        ser_data = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            ser_data[ch*BITS_PER_CLK +: BITS_PER_CLK] = r_shift[ch][BITS_PER_CLK-1:0];
        end
    end

    assign ser_clk        = r_clk_shift[BITS_PER_CLK-1:0];
    // Gated so a single-phase build does not strobe while held in reset.
    assign load_strobe    = w_load_cycle & reset_n;
    assign underrun       = r_underrun;
    assign underrun_count = r_underrun_count;
endmodule

// File: tb/tb_tmds_serializer.sv
// Bench for tmds_serializer: four widths (BPC 2, 1, 5, 10) each checked every cycle against a
// frame/queue model, plus directed checks on the BPC=2 instance.
module tb_tmds_serializer;
    localparam int         NUM_CH = 3;
    localparam logic [9:0] IDLE   = 10'b1101010100;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   vectors     = 0;
    int   miscompares = 0;
    bit   dir_mode    = 1'b1;

    logic        valid0 = 1'b0;
    logic [29:0] data0  = '0;
    logic        clr0   = 1'b0;

    logic        valid_r [4];
    logic [29:0] data_r  [4];
    logic        clr_r   [4];

    logic [29:0] sd_a    [4];
    logic [9:0]  sc_a    [4];
    logic        ready_a [4];
    logic        ls_a    [4];
    logic        ur_a    [4];
    logic [15:0] cnt_a   [4];

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Random stimulus; the valid density changes every 200 cycles to provoke underruns.
    initial begin : p_rand
        int dens;
        int cyc;
        dens = 7;
        cyc  = 0;
        for (int i = 0; i < 4; i++) begin
            valid_r[i] = 1'b0;
            data_r[i]  = '0;
            clr_r[i]   = 1'b0;
        end
        forever begin
            @(posedge clk);
            #2;
            cyc++;
            if (cyc % 200 == 0) dens = $urandom_range(1, 9);
            for (int i = 0; i < 4; i++) begin
                valid_r[i] = ($urandom_range(0, 9) < dens);
                data_r[i]  = 30'($urandom);
                clr_r[i]   = ($urandom_range(0, 255) == 0);
            end
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_cfg
        localparam int BPC = (gi == 0) ? 2 : (gi == 1) ? 1 : (gi == 2) ? 5 : 10;
        localparam int CW  = (gi == 0) ? 16 : 3;
        localparam int PH  = 10 / BPC;

        tmds_serializer_if #(.NUM_CH(NUM_CH)) u_if ();

        logic [NUM_CH*BPC-1:0] w_sd;
        logic [BPC-1:0]        w_sc;
        logic                  w_ls;
        logic                  w_ur;
        logic [CW-1:0]         w_cnt;
        logic                  w_clr;

        assign u_if.word_valid = (gi == 0 && dir_mode) ? valid0 : valid_r[gi];
        assign u_if.word_data  = (gi == 0 && dir_mode) ? data0  : data_r[gi];
        assign w_clr           = (gi == 0 && dir_mode) ? clr0   : clr_r[gi];

        tmds_serializer #(
            .NUM_CH      (NUM_CH),
            .BITS_PER_CLK(BPC),
            .IDLE_WORD   (IDLE),
            .CNT_W       (CW)
        ) u_dut (
            .clk_5x_pixel  (clk),
            .reset_n       (rst_n),
            .word_if       (u_if),
            .ser_data      (w_sd),
            .ser_clk       (w_sc),
            .load_strobe   (w_ls),
            .underrun      (w_ur),
            .underrun_count(w_cnt),
            .underrun_clr  (w_clr)
        );

        assign sd_a[gi]    = 30'(w_sd);
        assign sc_a[gi]    = 10'(w_sc);
        assign ready_a[gi] = u_if.word_ready;
        assign ls_a[gi]    = w_ls;
        assign ur_a[gi]    = w_ur;
        assign cnt_a[gi]   = 16'(w_cnt);

        // Model: cycle count since reset, the frame being emitted, and a one-deep word queue.
        logic [29:0] m_frame;
        logic [29:0] m_hold [$];
        int          m_t;
        int          m_cnt;
        bit          m_ur;

        initial begin : p_model
            m_frame = {NUM_CH{IDLE}};
            m_t     = 0;
            m_cnt   = 0;
            m_ur    = 1'b0;
            forever begin
                @(posedge clk or negedge rst_n);
                if (!rst_n) begin
                    m_hold.delete();
                    m_frame = {NUM_CH{IDLE}};
                    m_t     = 0;
                    m_cnt   = 0;
                    m_ur    = 1'b0;
                end else begin : step
                    bit load;
                    bit acc;
                    bit evt;
                    load = ((m_t % PH) == PH - 1);
                    acc  = u_if.word_valid && (m_hold.size() == 0 || load);
                    evt  = load && (m_hold.size() == 0);
                    if (load) begin
                        if (evt) m_frame = {NUM_CH{IDLE}};
                        else     m_frame = m_hold.pop_front();
                    end
                    if (acc) m_hold.push_back(u_if.word_data);
                    if (w_clr) begin
                        m_ur  = 1'b0;
                        m_cnt = 0;
                    end else if (evt) begin
                        m_ur = 1'b1;
                        if (m_cnt < (1 << CW) - 1) m_cnt++;
                    end
                    m_t++;
                end
            end
        end

        initial begin : p_cmp
            logic [NUM_CH*BPC-1:0] e_sd;
            logic [9:0]            pat;
            int                    ph;
            forever begin
                @(negedge clk);
                ph  = m_t % PH;
                pat = 10'b0000011111;
                for (int ch = 0; ch < NUM_CH; ch++) begin
                    e_sd[ch*BPC +: BPC] = m_frame[ch*10 + ph*BPC +: BPC];
                end
                check($sformatf("ser_data bpc%0d", BPC), 64'(w_sd), 64'(e_sd));
                check($sformatf("ser_clk bpc%0d", BPC), 64'(w_sc), 64'(pat[ph*BPC +: BPC]));
                check($sformatf("load_strobe bpc%0d", BPC), 64'(w_ls),
                      64'(rst_n && (ph == PH - 1)));
                check($sformatf("word_ready bpc%0d", BPC), 64'(u_if.word_ready),
                      64'((m_hold.size() == 0) || (ph == PH - 1)));
                check($sformatf("underrun bpc%0d", BPC), 64'(w_ur), 64'(m_ur));
                check($sformatf("underrun_count bpc%0d", BPC), 64'(w_cnt), 64'(m_cnt));
            end
        end
    end

    task automatic wait_load();
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (ls_a[0]) seen = 1'b1;
        end
        if (!seen) begin
            miscompares++;
            $display("FAIL wait_load timeout at %0t: got no load_strobe, expected one", $time);
        end
    endtask

    task automatic send(input logic [29:0] d);
        bit   done;
        logic r;
        done   = 1'b0;
        valid0 = 1'b1;
        data0  = d;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            r = ready_a[0];
            @(posedge clk);
            #2;
            clr0 = 1'b0;
            if (r) done = 1'b1;
        end
        if (!done) begin
            miscompares++;
            $display("FAIL send timeout at %0t: got no word_ready, expected accept", $time);
        end
    endtask

    initial begin : p_main
        logic [9:0] t1_d;
        logic [9:0] t1_c;
        t1_d = {2'b11, 2'b01, 2'b01, 2'b01, 2'b00};
        t1_c = {2'b00, 2'b00, 2'b01, 2'b11, 2'b11};

        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset ser_data", 64'(sd_a[0]), 64'({3{2'b00}}));
        check("reset ser_clk", 64'(sc_a[0][1:0]), 64'(2'b11));
        check("reset word_ready", 64'(ready_a[0]), 64'(1'b1));
        check("reset load_strobe", 64'(ls_a[0]), 64'(1'b0));
        check("reset underrun", 64'(ur_a[0]), 64'(1'b0));
        check("reset count", 64'(cnt_a[0]), 64'(16'd0));

        // Idle frame after release.
        @(posedge clk);
        #2 rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("idle ch0 phase%0d", k), 64'(sd_a[0][1:0]), 64'(t1_d[2*k +: 2]));
            check($sformatf("idle clk phase%0d", k), 64'(sc_a[0][1:0]), 64'(t1_c[2*k +: 2]));
        end

        // Streaming three words with valid held high; clear the start-up underruns.
        @(posedge clk);
        #2 clr0 = 1'b1;
        send(30'h3FF);
        send(30'h000);
        send(30'h155);
        valid0 = 1'b0;
        wait_load();
        @(negedge clk);
        check("stream ch0 first pair", 64'(sd_a[0][1:0]), 64'(2'b01));
        check("stream underrun", 64'(ur_a[0]), 64'(1'b0));
        check("stream count", 64'(cnt_a[0]), 64'(16'd0));

        // Underrun over two load points.
        wait_load();
        wait_load();
        @(negedge clk);
        check("underrun set", 64'(ur_a[0]), 64'(1'b1));
        check("underrun count 2", 64'(cnt_a[0]), 64'(16'd2));
        check("underrun idle ch0", 64'(sd_a[0][1:0]), 64'(2'b00));
        @(posedge clk);
        #2 clr0 = 1'b1;
        @(posedge clk);
        #2 clr0 = 1'b0;
        @(negedge clk);
        check("clear underrun", 64'(ur_a[0]), 64'(1'b0));
        check("clear count", 64'(cnt_a[0]), 64'(16'd0));

        // Backpressure: holding register full mid-frame.
        wait_load();
        @(posedge clk);
        #2;
        valid0 = 1'b1;
        data0  = 30'h3FF;
        @(posedge clk);
        #2 data0 = 30'h2AA;
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("backpressure ready phase%0d", k), 64'(ready_a[0]), 64'(1'b0));
        end
        @(negedge clk);
        check("backpressure ready load", 64'(ready_a[0]), 64'(1'b1));
        check("backpressure load_strobe", 64'(ls_a[0]), 64'(1'b1));
        @(posedge clk);
        #2 valid0 = 1'b0;
        @(negedge clk);
        check("backpressure word A", 64'(sd_a[0][1:0]), 64'(2'b11));
        wait_load();
        @(negedge clk);
        check("backpressure word B", 64'(sd_a[0][1:0]), 64'(2'b10));

        // Reset at phase 3 with a word held.
        wait_load();
        @(posedge clk);
        #2;
        valid0 = 1'b1;
        data0  = 30'h2345678;
        @(posedge clk);
        #2 valid0 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async reset ser_data", 64'(sd_a[0]), 64'({3{2'b00}}));
        check("async reset ser_clk", 64'(sc_a[0][1:0]), 64'(2'b11));
        check("async reset ready", 64'(ready_a[0]), 64'(1'b1));
        check("async reset load_strobe", 64'(ls_a[0]), 64'(1'b0));
        check("async reset underrun", 64'(ur_a[0]), 64'(1'b0));
        check("async reset count", 64'(cnt_a[0]), 64'(16'd0));
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        wait_load();
        @(negedge clk);
        check("held word discarded", 64'(sd_a[0]), 64'({3{2'b00}}));
        check("post-reset count", 64'(cnt_a[0]), 64'(16'd1));

        // Random traffic on all widths, including one reset in the middle.
        @(posedge clk);
        #2 dir_mode = 1'b0;
        repeat (4000) @(posedge clk);
        #3 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (2000) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
